// File: rtl/jt49_wrseq.sv
// ============================================================================
// Module      : jt49_wrseq
// Description : Command FIFO plus bus sequencer for a JT49/AY-3-8910 PSG.
//               Host commands are queued and replayed on the PSG bus as
//               SETUP / STROBE (HOLD cen ticks) / RECOVER phases. Reads
//               capture psg_dout at the end of the strobe.
//               Optional build macro JT49_WRSEQ_DEDUP_EN adds a 16x8 shadow
//               of written values; redundant writes (except reg 13, the
//               envelope shape/restart register) are dropped without a bus
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt49_wrseq #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic [3:0] psg_addr,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    input  logic [7:0] psg_dout,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy
);

    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         EW          = 13;
    localparam logic [AW:0] C_FULL     = (AW+1)'(DEPTH);
    localparam logic [3:0] C_HOLD_LAST = 4'(HOLD - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_STROBE  = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    logic [EW-1:0] fifo_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    logic [1:0] state_q, state_d;
    logic [3:0] tick_q, tick_d;

    logic       rd_q;
    logic [3:0] addr_q;
    logic [7:0] din_q;
    logic       rd_valid_q;
    logic [7:0] rd_data_q;

    logic          w_push, w_pop, w_issue, w_skip, w_strobe_done;
    logic [EW-1:0] w_head;
    logic          w_head_rd;
    logic [3:0]    w_head_addr;
    logic [7:0]    w_head_data;

    assign req_ready   = (cnt_q != C_FULL);
    assign w_push      = req_valid & req_ready;
    // Pop only what was already stored before this edge: no bypass path.
    assign w_pop       = cen & (state_q == ST_IDLE) & (cnt_q != '0);
    assign w_head      = fifo_q[rptr_q];
    assign w_head_rd   = w_head[12];
    assign w_head_addr = w_head[11:8];
    assign w_head_data = w_head[7:0];
    assign w_issue     = w_pop & ~w_skip;
    assign w_strobe_done = (state_q == ST_STROBE) & cen & (tick_q == C_HOLD_LAST);

`ifdef JT49_WRSEQ_DEDUP_EN
    logic [7:0] shadow_q [16];

    // Reg 13 always issues because writing it restarts the envelope.
    assign w_skip = ~w_head_rd & (w_head_addr != 4'd13)
                  & (shadow_q[w_head_addr] == w_head_data);

    // Shadow tracks the last value actually written to each PSG register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) shadow_q[i] <= 8'd0;
        end else if (w_issue && !w_head_rd) begin
            shadow_q[w_head_addr] <= w_head_data;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) fifo_q[wptr_q] <= {req_rd, req_addr, req_data};
    end

    // FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
            if (w_push && !w_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!w_push && w_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    // FSM state and strobe tick counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    // FSM next state; every transition waits for a cen tick.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        case (state_q)
            ST_IDLE: begin
                if (w_issue) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cen) begin
                    state_d = ST_STROBE;
                    tick_d  = 4'd0;
                end
            end
            ST_STROBE: begin
                if (cen) begin
                    if (tick_q == C_HOLD_LAST) state_d = ST_RECOVER;
                    else                       tick_d  = tick_q + 4'd1;
                end
            end
            default: begin
                if (cen) state_d = ST_IDLE;
            end
        endcase
    end

    // Bus control outputs decoded from the current state.
    always_comb begin
        psg_cs_n = 1'b1;
        psg_wr_n = 1'b1;
        if (state_q == ST_STROBE) begin
            psg_cs_n = 1'b0;
            psg_wr_n = rd_q;
        end
    end

    // Latch the popped command; held stable until the next issued command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= 1'b0;
            addr_q <= 4'd0;
            din_q  <= 8'd0;
        end else if (w_issue) begin
            rd_q   <= w_head_rd;
            addr_q <= w_head_addr;
            din_q  <= w_head_data;
        end
    end

    // Capture read data on the edge that ends the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            rd_valid_q <= w_strobe_done & rd_q;
            if (w_strobe_done && rd_q) rd_data_q <= psg_dout;
        end
    end

    assign psg_addr = addr_q;
    assign psg_din  = din_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = (cnt_q != '0) | (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/jt49_wrseq.md
JT49_WRSEQ -- requirements
Module: jt49_wrseq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, command FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter HOLD, default 2, strobe length in cen ticks (1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cen  input  1  clock enable pacing bus phases.
REQ-006 SHALL have port req_valid  input  1  host command valid.
REQ-007 SHALL have port req_ready  output  1  FIFO can accept a command.
REQ-008 SHALL have port req_rd  input  1  1 = register read, 0 = write.
REQ-009 SHALL have port req_addr  input  4  PSG register index.
REQ-010 SHALL have port req_data  input  8  write data (ignored on reads).
REQ-011 SHALL have port psg_addr  output  4  to PSG addr.
REQ-012 SHALL have port psg_cs_n  output  1  to PSG cs_n.
REQ-013 SHALL have port psg_wr_n  output  1  to PSG wr_n.
REQ-014 SHALL have port psg_din  output  8  to PSG din.
REQ-015 SHALL have port psg_dout  input  8  from PSG dout.
REQ-016 SHALL have port rd_valid  output  1  one-clk pulse, read data ready.
REQ-017 SHALL have port rd_data  output  8  captured read data.
REQ-018 SHALL have port busy  output  1  FIFO non-empty or state not IDLE.

Function
REQ-019 Push SHALL occur on clk edge with req_valid & req_ready, independent of cen; entry = {rd, addr, data}.
REQ-020 req_ready SHALL be 0 exactly when FIFO holds DEPTH entries; pushes while full are dropped and FIFO unchanged.
REQ-021 FSM states SHALL be IDLE, SETUP, STROBE, RECOVER; transitions only on cen=1 clocks.
REQ-022 IDLE: if FIFO non-empty at a cen tick, pop head into bus registers, go SETUP; empty-FIFO pop SHALL never occur (no push-to-pop bypass in same clk).
REQ-023 SETUP: psg_addr/psg_din driven from popped entry, cs_n=1, wr_n=1, for 1 cen tick, then STROBE.
REQ-024 STROBE: cs_n=0, wr_n=0 for writes / 1 for reads, for exactly HOLD cen ticks (4-bit tick counter), then RECOVER.
REQ-025 On the clk edge leaving STROBE for a read, rd_data SHALL load psg_dout and rd_valid SHALL pulse high for that single clk.
REQ-026 RECOVER: cs_n=1, wr_n=1 for 1 cen tick, then IDLE; back-to-back commands therefore take HOLD+3 cen ticks each.
REQ-027 psg_addr/psg_din SHALL stay stable from SETUP through RECOVER.
REQ-028 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
REQ-030 Commands SHALL be issued strictly in push order.

Reset
REQ-031 While rst=1: FIFO empty, state IDLE, req_ready=1, busy=0, psg_cs_n=1, psg_wr_n=1, psg_addr=0, psg_din=0, rd_valid=0, rd_data=0, shadow (if present) all 0.
REQ-032 Reset asserted mid-cycle SHALL abort immediately; cs_n returns high asynchronously, no rd_valid issued.

Configuration
REQ-033 Macro JT49_WRSEQ_DEDUP_EN SHALL, when defined, add a 16x8 shadow of last written values and discard (pop with no bus cycle, 1 cen tick) writes whose data equals the shadow, except register 13, which always issues (envelope restart).
REQ-034 Without JT49_WRSEQ_DEDUP_EN every write SHALL issue a bus cycle and no shadow SHALL exist; reads are never deduplicated in either build.

Verification
REQ-035 cen=1 always, HOLD=2, push write addr 7 data 0x38 -> SETUP 1 clk, cs_n=wr_n=0 for 2 clks with addr=7 din=0x38, RECOVER 1 clk, busy low after.
REQ-036 Push 9 writes back-to-back with cen held 0, DEPTH=8 -> req_ready low after 8th, 9th dropped; enabling cen issues exactly 8 cycles in order.
REQ-037 Read addr 0 with psg_dout=0xA5 during STROBE, wr_n stays 1 -> rd_valid one clk, rd_data=0xA5.
REQ-038 cen every 4th clk -> each phase lasts 4 clks, total (HOLD+3)*4 clks per command.
REQ-039 DEDUP build: write reg 8=0x0F twice, then reg 13=0x0E twice -> 3 bus cycles; non-DEDUP build -> 4.
REQ-040 Assert rst during STROBE -> cs_n=1 same time, FIFO empty, no rd_valid, req_ready=1.
